// File: rtl/seq_detect_param.sv
// Serial pattern detector: runtime pattern/length/overlap, saturating match counter, hex 7-seg readout.
// Latency: match, match_count and det update on the edge that accepts the final pattern bit; seg is combinational.
// Backpressure: none; accepts one bit per clock when ena && bit_valid, and ena low freezes all state.
module seq_detect_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               bit_in,
  input  logic               bit_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  input  logic               clr_count,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic [7:0]         seg
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // Latched configuration
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;

  // Detection state
  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;
  logic               det;

  // Combinational helpers
  logic               load;
  logic               accept;
  logic [LEN_W-1:0]   len_clamp;
  logic [MAX_LEN-1:0] hist_next;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill_inc;
  logic [LEN_W:0]     fill_p1;
  logic               enough_bits;
  logic               pat_equal;
  logic               hit;

  // Qualify strobes: a configuration load wins over a same-cycle bit
  always_comb begin
    load   = ena & cfg_load;
    accept = ena & bit_valid & ~cfg_load;
  end

  // Clamp the requested length so the compare window never exceeds the history
  always_comb begin
    len_clamp = pat_len;
    if (pat_len > MAX_LEN_L) begin
      len_clamp = MAX_LEN_L;
    end
  end

  // Post-shift history: newest bit lands in bit 0 and is compared with pattern[0]
  always_comb begin
    hist_next = {hist[MAX_LEN-2:0], bit_in};
  end

  // Mask selecting the low len_q bits of history/pattern for the compare
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
  end

  // Fill counter arithmetic: saturating increment plus the one-ahead value used for gating
  always_comb begin
    fill_inc = fill;
    if (fill != MAX_LEN_L) begin
      fill_inc = fill + LEN_W'(1);
    end
    fill_p1     = {1'b0, fill} + (LEN_W + 1)'(1);
    enough_bits = (fill_p1 >= {1'b0, len_q});
  end

  // Match decision on the accepted bit using the post-shift history
  always_comb begin
    pat_equal = (((hist_next ^ pat_q) & len_mask) == '0);
    hit       = accept && (len_q != '0) && enough_bits && pat_equal;
  end

  // Configuration registers, loaded only while enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q <= '0;
      len_q <= '0;
      ovl_q <= 1'b1;
    end else if (load) begin
      pat_q <= pattern;
      len_q <= len_clamp;
      ovl_q <= overlap;
    end
  end

  // History and fill: cleared by a load, advanced per accepted bit, fill restarts after a non-overlap match
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      fill <= '0;
    end else if (load) begin
      hist <= '0;
      fill <= '0;
    end else if (accept) begin
      hist <= hist_next;
      if (hit && !ovl_q) begin
        fill <= '0;
      end else begin
        fill <= fill_inc;
      end
    end
  end

  // One-cycle match pulse; hit already requires ena, so disabled cycles force it low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match <= 1'b0;
    end else begin
      match <= hit;
    end
  end

  // Saturating counter and sticky detect; clear beats a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_count <= '0;
      det         <= 1'b0;
    end else if (ena) begin
      if (clr_count) begin
        match_count <= '0;
        det         <= 1'b0;
      end else if (hit) begin
        det <= 1'b1;
        if (match_count != CNT_MAX) begin
          match_count <= match_count + CNT_W'(1);
        end
      end
    end
  end

  // Hex glyph of the low count nibble with the detect latch on the decimal point
  always_comb begin
    seg = 8'h00;
    unique case (match_count[3:0])
      4'h0: seg[6:0] = 7'h3F;
      4'h1: seg[6:0] = 7'h06;
      4'h2: seg[6:0] = 7'h5B;
      4'h3: seg[6:0] = 7'h4F;
      4'h4: seg[6:0] = 7'h66;
      4'h5: seg[6:0] = 7'h6D;
      4'h6: seg[6:0] = 7'h7D;
      4'h7: seg[6:0] = 7'h07;
      4'h8: seg[6:0] = 7'h7F;
      4'h9: seg[6:0] = 7'h6F;
      4'hA: seg[6:0] = 7'h77;
      4'hB: seg[6:0] = 7'h7C;
      4'hC: seg[6:0] = 7'h39;
      4'hD: seg[6:0] = 7'h5E;
      4'hE: seg[6:0] = 7'h79;
      4'hF: seg[6:0] = 7'h71;
      default: seg[6:0] = 7'h00;
    endcase
    seg[7] = det;
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param (MAX_LEN=16, CNT_W=4): scoreboard of per-cycle expectations plus directed checks.
// Latency: each driven cycle's expectation is compared 1 ns after the following rising edge.
// Backpressure: none; stimulus is applied every cycle on the falling edge.
module tb_seq_detect_param;

  localparam int ML = 16;
  localparam int CW = 4;
  localparam int LW = $clog2(ML) + 1;

  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct packed {
    logic          match;
    logic [CW-1:0] cnt;
    logic [7:0]    seg;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          ena;
  logic          bit_in;
  logic          bit_valid;
  logic          cfg_load;
  logic [ML-1:0] pattern;
  logic [LW-1:0] pat_len;
  logic          overlap;
  logic          clr_count;
  logic          match;
  logic [CW-1:0] match_count;
  logic [7:0]    seg;

  seq_detect_param #(.MAX_LEN(ML), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .cfg_load    (cfg_load),
    .pattern     (pattern),
    .pat_len     (pat_len),
    .overlap     (overlap),
    .clr_count   (clr_count),
    .match       (match),
    .match_count (match_count),
    .seg         (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int obs_pulses = 0;
  int base;

  exp_t sb_q [$];
  exp_t mon_e;

  // Reference model state
  logic [ML-1:0] m_pat;
  int            m_len;
  logic          m_ovl;
  int            m_cnt;
  logic          m_det;
  bit            m_seen [$];

  // Current configuration used by the directed helpers
  logic [ML-1:0] cur_pat;
  logic [LW-1:0] cur_len;
  logic          cur_ovl;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_pat = '0;
    m_len = 0;
    m_ovl = 1'b1;
    m_cnt = 0;
    m_det = 1'b0;
    m_seen.delete();
    sb_q.delete();
  endtask

  task automatic model_step(input logic e, input logic bv, input logic b, input logic cl,
                            input logic [ML-1:0] p, input logic [LW-1:0] l, input logic o,
                            input logic clr);
    exp_t ex;
    logic hit;
    hit = 1'b0;
    if (e) begin
      if (cl) begin
        m_pat = p;
        m_len = (int'(l) > ML) ? ML : int'(l);
        m_ovl = o;
        m_seen.delete();
      end else if (bv) begin
        m_seen.push_back(b);
        if (m_seen.size() > ML) m_seen.delete(0);
        if (m_len != 0 && m_seen.size() >= m_len) begin
          hit = 1'b1;
          for (int k = 0; k < m_len; k++) begin
            if (m_seen[m_seen.size() - 1 - k] != m_pat[k]) hit = 1'b0;
          end
        end
        if (hit && !m_ovl) m_seen.delete();
      end
      if (clr) begin
        m_cnt = 0;
        m_det = 1'b0;
      end else if (hit) begin
        if (m_cnt != 15) m_cnt++;
        m_det = 1'b1;
      end
    end
    ex.match = hit;
    ex.cnt   = CW'(m_cnt);
    ex.seg   = {m_det, GLYPH[m_cnt]};
    sb_q.push_back(ex);
  endtask

  // Apply one cycle of stimulus on the falling edge and queue its expectation
  task automatic drive(input logic e, input logic bv, input logic b, input logic cl,
                       input logic [ML-1:0] p, input logic [LW-1:0] l, input logic o,
                       input logic clr);
    @(negedge clk);
    ena = e; bit_valid = bv; bit_in = b; cfg_load = cl;
    pattern = p; pat_len = l; overlap = o; clr_count = clr;
    model_step(e, bv, b, cl, p, l, o, clr);
  endtask

  task automatic send_bit(input logic b);
    drive(1'b1, 1'b1, b, 1'b0, cur_pat, cur_len, cur_ovl, 1'b0);
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    logic [31:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic load_cfg(input logic [ML-1:0] p, input logic [LW-1:0] l, input logic o);
    cur_pat = p; cur_len = l; cur_ovl = o;
    drive(1'b1, 1'b0, 1'b0, 1'b1, p, l, o, 1'b0);
  endtask

  task automatic clr_cnt();
    drive(1'b1, 1'b0, 1'b0, 1'b0, cur_pat, cur_len, cur_ovl, 1'b1);
  endtask

  // Let the last driven cycle reach the DUT and the monitor
  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  // Monitor: pop one expectation per edge and compare
  always @(posedge clk) begin
    #1;
    if (!rst && sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      chk("sb_match", 32'(match), 32'(mon_e.match));
      chk("sb_count", 32'(match_count), 32'(mon_e.cnt));
      chk("sb_seg", 32'(seg), 32'(mon_e.seg));
      if (match === 1'b1) obs_pulses++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    cur_pat = '0; cur_len = '0; cur_ovl = 1'b1;

    // Reset with random inputs applied
    rst = 1'b1;
    ena = 1'($urandom); bit_in = 1'($urandom); bit_valid = 1'($urandom);
    cfg_load = 1'($urandom); pattern = ML'($urandom); pat_len = LW'($urandom);
    overlap = 1'($urandom); clr_count = 1'($urandom);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_seg", 32'(seg), 32'h3F);
    chk("rst_match", 32'(match), 32'h0);
    chk("rst_count", 32'(match_count), 32'h0);
    @(negedge clk);
    ena = 1'b0; bit_valid = 1'b0; cfg_load = 1'b0; clr_count = 1'b0;
    rst = 1'b0;

    // Overlapping detection: 1011 in 1011011 -> bits 4 and 7
    load_cfg(16'b1011, 5'd4, 1'b1);
    base = obs_pulses;
    send_bits(32'b1011011, 7);
    sync();
    chk("ovl_pulses", 32'(obs_pulses - base), 32'd2);
    chk("ovl_count", 32'(match_count), 32'd2);
    chk("ovl_seg", 32'(seg), 32'hDB);

    // Asynchronous reset mid-stream
    send_bit(1'b1);
    sync();
    rst = 1'b1;
    #1;
    chk("rst_mid_seg", 32'(seg), 32'h3F);
    chk("rst_mid_count", 32'(match_count), 32'h0);
    chk("rst_mid_match", 32'(match), 32'h0);
    @(negedge clk);
    ena = 1'b0; bit_valid = 1'b0; cfg_load = 1'b0; clr_count = 1'b0;
    rst = 1'b0;
    model_reset();

    // Non-overlapping: 1011011 -> one match at bit 4
    load_cfg(16'b1011, 5'd4, 1'b0);
    base = obs_pulses;
    send_bits(32'b1011, 4);
    sync();
    chk("novl_first", 32'(obs_pulses - base), 32'd1);
    send_bits(32'b011, 3);
    sync();
    chk("novl_total", 32'(obs_pulses - base), 32'd1);
    // Reload, 10111011 -> matches at bits 4 and 8
    load_cfg(16'b1011, 5'd4, 1'b0);
    base = obs_pulses;
    send_bits(32'b10111011, 8);
    sync();
    chk("novl2_pulses", 32'(obs_pulses - base), 32'd2);
    chk("novl2_count", 32'(match_count), 32'd3);

    // ena low mid-pattern: bits, loads and clears all ignored
    load_cfg(16'b1011, 5'd4, 1'b1);
    base = obs_pulses;
    send_bits(32'b10, 2);
    repeat (3) drive(1'b0, 1'b1, 1'($urandom), 1'b1, 16'hFFFF, 5'd2, 1'b0, 1'b1);
    send_bits(32'b11, 2);
    sync();
    chk("gate_pulses", 32'(obs_pulses - base), 32'd1);
    chk("gate_count", 32'(match_count), 32'd4);

    // cfg_load with bit_valid: bit discarded, history restarts
    send_bits(32'b101, 3);
    base = obs_pulses;
    drive(1'b1, 1'b1, 1'b1, 1'b1, cur_pat, cur_len, cur_ovl, 1'b0);
    send_bit(1'b1);
    sync();
    chk("cfgpri_none", 32'(obs_pulses - base), 32'd0);
    send_bits(32'b011, 3);
    sync();
    chk("cfgpri_one", 32'(obs_pulses - base), 32'd1);

    // Saturation at 15 with pattern 11 and 21 ones
    load_cfg(16'b11, 5'd2, 1'b1);
    clr_cnt();
    base = obs_pulses;
    repeat (21) send_bit(1'b1);
    sync();
    chk("sat_pulses", 32'(obs_pulses - base), 32'd20);
    chk("sat_count", 32'(match_count), 32'd15);
    chk("sat_seg", 32'(seg[6:0]), 32'h71);
    // Clear on a match cycle: pulse still fires, count and det cleared
    drive(1'b1, 1'b1, 1'b1, 1'b0, cur_pat, cur_len, cur_ovl, 1'b1);
    sync();
    chk("clr_match", 32'(match), 32'h1);
    chk("clr_count", 32'(match_count), 32'h0);
    chk("clr_seg", 32'(seg), 32'h3F);

    // Length zero never matches
    load_cfg(16'h0000, 5'd0, 1'b1);
    base = obs_pulses;
    repeat (16) send_bit(1'b0);
    repeat (16) send_bit(1'($urandom));
    sync();
    chk("len0_pulses", 32'(obs_pulses - base), 32'd0);

    // Over-length request clamps to 16
    load_cfg(16'hA5C3, 5'd19, 1'b1);
    base = obs_pulses;
    send_bits(32'hA5C3 >> 1, 15);
    sync();
    chk("clamp_early", 32'(obs_pulses - base), 32'd0);
    send_bit(1'b1);
    sync();
    chk("clamp_hit", 32'(obs_pulses - base), 32'd1);

    // All-ones 16-bit pattern: first match on bit 16, then every bit
    load_cfg(16'hFFFF, 5'd16, 1'b1);
    base = obs_pulses;
    repeat (15) send_bit(1'b1);
    sync();
    chk("ones_early", 32'(obs_pulses - base), 32'd0);
    send_bit(1'b1);
    sync();
    chk("ones_first", 32'(obs_pulses - base), 32'd1);
    repeat (4) send_bit(1'b1);
    sync();
    chk("ones_run", 32'(obs_pulses - base), 32'd5);

    // Random traffic checked by the scoreboard
    for (int n = 0; n < 400; n++) begin
      logic          e, bv, cl, clr, o;
      logic [LW-1:0] l;
      e   = ($urandom_range(0, 99) < 85);
      bv  = ($urandom_range(0, 99) < 80);
      cl  = ($urandom_range(0, 99) < 5);
      clr = ($urandom_range(0, 99) < 3);
      o   = 1'($urandom);
      l   = ($urandom_range(0, 9) == 0) ? LW'(19) : LW'($urandom_range(0, 5));
      drive(e, bv, 1'($urandom), cl, ML'($urandom), l, o, clr);
    end
    sync();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial pattern detector, the next generation of the fixed 3-bit sequence detector. The pattern, pattern length and overlap mode are runtime-configurable. Matches are counted with saturation, and the low count nibble is shown on the 7-segment output together with a sticky "detected" point. The block sits between the user input pins (serial bit, valid, configuration) and the `uo_out` segment bus of the top wrapper.

## Interface
- `MAX_LEN`, default 8: maximum pattern length in bits (2..16).
- `CNT_W`, default 8: match counter width (4..16).
- `LEN_W`, default `$clog2(MAX_LEN)+1`: width of `pat_len`. Derived; never overridden.

Ports (clock and reset first):
- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `ena`  in  1: block enable; when low, all state holds.
- `bit_in`  in  1: serial data bit.
- `bit_valid`  in  1: `bit_in` is accepted on this edge.
- `cfg_load`  in  1: latch `pattern`, `pat_len` and `overlap`.
- `pattern`  in  MAX_LEN: pattern, LSB-aligned.
- `pat_len`  in  LEN_W: active pattern length.
- `overlap`  in  1: 1 = overlapping matches allowed.
- `clr_count`  in  1: synchronous clear of the counter and the detected latch.
- `match`  out  1: one-cycle pulse per detected pattern.
- `match_count`  out  CNT_W: saturating match count.
- `seg`  out  8: {dp,g,f,e,d,c,b,a}; 1 = segment lit.

## Operation
- Configuration registers: `pat_q`, `len_q`, `ovl_q`.
  - Reset values: `pat_q`=0, `len_q`=0, `ovl_q`=1.
  - Loaded when `ena && cfg_load`.
  - If `pat_len` > MAX_LEN, `len_q` is clamped to MAX_LEN.
  - `len_q`=0 disables detection; `match` is never asserted.
- Loading the configuration also clears `hist` and `fill`, restarting detection.
- History shift register `hist[MAX_LEN-1:0]`, reset 0.
  - Accepted bit (`ena && bit_valid && !cfg_load`): `hist <= {hist[MAX_LEN-2:0], bit_in}`.
  - Bit order: the first-received pattern bit is compared with `pattern[len-1]`; the last-received bit is compared with `pattern[0]`.
- Fill counter `fill`, reset 0.
  - Increments per accepted bit and saturates at MAX_LEN.
  - Purpose: no match can be declared before `len_q` bits have been seen since reset, configuration load or a non-overlap match.
- Match condition, evaluated on an accepted bit using the post-shift history: `(fill+1 >= len_q) && len_q != 0 && hist_next[len_q-1:0] == pat_q[len_q-1:0]`.
- On a match:
  - `match` pulses for exactly one cycle.
  - `match_count` increments, saturating at 2^CNT_W-1.
  - The detected latch `det` is set.
  - If `ovl_q`=0, `fill` is set to 0 instead of incrementing.
- `ena`=0: no bit is accepted, `cfg_load` and `clr_count` are ignored, all registers hold, and `match` is forced to 0 on the next edge.
- Priority within one edge:
  - `cfg_load` over `bit_valid`: the bit is discarded and the configuration is loaded.
  - `clr_count` over a same-cycle match increment: count=0 and `det`=0, but the `match` pulse still asserts.
- Segment output (combinational from registers):
  - `seg[6:0]` = hex glyph of `match_count[3:0]`: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
  - `seg[7]` = `det`.

## Timing
- Reset values: `match`=0, `match_count`=0, `det`=0, `seg`=8'h3F; all internal state is 0 except `ovl_q`=1.
- Assertion of `rst` clears all state immediately, independent of `clk`, including mid-stream. Deassertion is synchronised by the wrapper.
- Latency:
  - `match`, `match_count` and `det` update on the same edge that accepts the final pattern bit, i.e. they are visible in the cycle after `bit_valid` is presented.
  - `seg` follows `match_count` and `det` with no additional delay.
- Throughput: one bit per clock. Back-to-back overlapping matches on consecutive cycles are legal; example: pattern `11`, input `111` gives 2 matches.
- A configuration load takes effect on the following accepted bit. A match can occur no earlier than `len_q` accepted bits after the load.

## Test plan
- Reset: assert `rst` with random inputs -> `seg`=8'h3F, `match`=0, `match_count`=0. Re-assert `rst` mid-stream -> same values immediately, without waiting for a clock edge.
- Overlap: load `pattern`=4'b1011, `pat_len`=4, `overlap`=1; stream 1,0,1,1,0,1,1 -> `match` pulses after bits 4 and 7; `match_count`=2; `seg`=8'hDB.
- Non-overlap: same pattern with `overlap`=0.
  - Stream 1011011 -> one match, after bit 4.
  - Then reload and stream 10111011 -> matches after bits 4 and 8.
- Gating and priority:
  - `ena`=0 for 3 cycles mid-pattern with `bit_valid`=1 -> no state change; the pattern completes after `ena` returns.
  - `cfg_load` with `bit_valid` on the same cycle -> the bit is discarded and `fill`=0.
- Saturation: CNT_W=4, 20 matches -> `match_count`=15 and `seg[6:0]`=71. `clr_count` on a match cycle -> `match`=1, `match_count`=0, `seg`=8'h3F.
- Limits: `pat_len`=0 -> no matches on any stream. `pat_len`=MAX_LEN+3 -> behaves as MAX_LEN. MAX_LEN=16 with an all-ones pattern -> first match on bit 16, then one match every bit while `overlap`=1.
